// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake,
// presents one instruction at a time and traps on a misaligned next PC.
module fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC0_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [1:0]            PCSrc,
  input  logic [DATA_WIDTH-1:0] ImmExt,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  instr_valid,
  output logic                  misaligned
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  load_instr;
  logic                  load_pc;
  logic [DATA_WIDTH-1:0] next_pc;

  assign pc_plus4  = pc + DATA_WIDTH'(4);
  assign imem_addr = pc;

  // Branch/jump target selection; PCSrc=11 falls back to sequential.
  always_comb begin
    next_pc = pc_plus4;
    unique case (PCSrc)
      2'b01:   next_pc = pc + ImmExt;
      2'b10:   next_pc = {alu_result[DATA_WIDTH-1:1], 1'b0};
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_next  = state;
    load_instr  = 1'b0;
    load_pc     = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    misaligned  = 1'b0;
    unique case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load_instr = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (!stall) begin
          // A misaligned target leaves pc on the faulting instruction.
          if (next_pc[1:0] != 2'b00) begin
            state_next = FAULT;
          end else begin
            load_pc    = 1'b1;
            state_next = FETCH;
          end
        end
      end
      FAULT: begin
        misaligned = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      instr <= NOP;
    end else begin
      state <= state_next;
      if (load_instr) instr <= imem_rdata;
      if (load_pc)    pc    <= next_pc;
    end
  end

endmodule
